// File: rtl/push_arb.sv
// push_arb: shares one downstream push port among NUM_REQ requesters.
// Arbitration is round-robin at packet granularity: once a requester's packet
// has started (or a single beat is stalled), the grant is held until the beat
// carrying push_last is accepted.
//
// Handshake: a beat moves when valid and ready are both high at a rising clk
// edge. Valid never waits on ready. Ready may depend combinationally on
// valid. The selected requester sees push_ready on its req_ready bit. Every
// other requester sees 0.
//
// The FSM state is visible on busy (high in LOCKED).
module push_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_payload,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic                      push_valid,
  input  logic                      push_ready,
  output logic [DATA_W-1:0]         push_payload,
  output logic                      push_last,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_win;
  logic [ID_W-1:0]   w_idle_sel;
  logic [ID_W-1:0]   w_sel;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic              w_found;
  logic              w_locked;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_payload;
  logic              w_accept_last;

  assign w_locked = (r_state == ST_LOCKED);

  // Round-robin scan: the valid requester with the smallest distance from r_ptr
  always_comb begin : rr_scan
    int v_ptr;
    int v_dist;
    int v_best;
    v_ptr      = int'(r_ptr);
    v_dist     = 0;
    v_best     = NUM_REQ;
    w_found    = 1'b0;
    w_idle_sel = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_dist = (i >= v_ptr) ? (i - v_ptr) : (i + NUM_REQ - v_ptr);
      if (req_valid[i] && (v_dist < v_best)) begin
        v_best     = v_dist;
        w_found    = 1'b1;
        w_idle_sel = ID_W'(i);
      end
    end
  end

  // A held grant overrides the scan so other requesters cannot cut in mid-packet
  assign w_sel = w_locked ? r_win : w_idle_sel;

  // Mux the selected requester's valid, last and payload
  always_comb begin
    w_sel_valid   = 1'b0;
    w_sel_last    = 1'b0;
    w_sel_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == ID_W'(i)) begin
        w_sel_valid   = req_valid[i];
        w_sel_last    = req_last[i];
        w_sel_payload = req_payload[i*DATA_W +: DATA_W];
      end
    end
  end

  // Outputs are gated by rst_n so they drop at once when reset asserts.
  // They do not wait for the next clock edge.
  assign push_valid   = rst_n & w_sel_valid;
  assign push_payload = w_sel_payload;
  assign push_last    = w_sel_last;
  assign grant_id     = rst_n ? w_sel : '0;
  assign busy         = w_locked;

  // Only the selected requester sees push_ready.
  // In IDLE with no request, nobody is selected.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n & push_ready & (w_locked | w_found) & (w_sel == ID_W'(i));
    end
  end

  assign w_accept_last = push_valid & push_ready & push_last;

  // After a packet ends, priority moves to the requester after the winner
  assign w_ptr_nxt = (int'(w_sel) == NUM_REQ - 1) ? '0 : (w_sel + 1'b1);

  // Next-state logic: lock on any presented beat that does not end the packet
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (push_valid && !w_accept_last) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_accept_last)                w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State, winner and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_LOCKED)) begin
        r_win <= w_sel;
      end
      if (w_accept_last) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  // At most one requester may be offered ready in any cycle
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: tb/tb_push_arb.sv
// Bench for push_arb.
// Stimulus: per-requester source queues with random packets and random valid/ready.
// Reference: a round-robin model at packet level, plus per-requester expected
// beat queues that are popped on every accepted push beat.
module tb_push_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_last;
  logic [N*DW-1:0] req_payload;
  logic            push_valid, push_ready, push_last, busy;
  logic [DW-1:0]   push_payload;
  logic [IW-1:0]   grant_id;

  logic [0:0]    r1_valid, r1_ready, r1_last;
  logic [DW-1:0] r1_payload, p1_payload;
  logic          p1_valid, p1_ready, p1_last, b1;
  logic [0:0]    g1;

  push_arb #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_payload(req_payload), .req_last(req_last), .push_valid(push_valid),
    .push_ready(push_ready), .push_payload(push_payload), .push_last(push_last),
    .grant_id(grant_id), .busy(busy)
  );

  push_arb #(.NUM_REQ(1), .DATA_W(DW), .ID_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(r1_valid), .req_ready(r1_ready),
    .req_payload(r1_payload), .req_last(r1_last), .push_valid(p1_valid),
    .push_ready(p1_ready), .push_payload(p1_payload), .push_last(p1_last),
    .grant_id(g1), .busy(b1)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0] src_q [N][$];
  logic [DW:0] exp_q [N][$];
  int acc_log[$];
  int m_owner = -1;
  int m_ptr = 0;
  int wait_cnt [N];
  int valid_pct = 100;
  int ready_pct = 100;
  logic [N-1:0] hold_mask = '0;
  int seq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 50) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_pkt(input int i, input int len);
    logic [DW:0] b;
    for (int k = 0; k < len; k++) begin
      b = {(k == len - 1), 8'(i), 24'(seq)};
      seq++;
      src_q[i].push_back(b);
      exp_q[i].push_back(b);
    end
  endtask

  task automatic drive();
    logic [DW:0] h;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_payload[i*DW +: DW] = h[DW-1:0];
        req_last[i]  = h[DW];
        req_valid[i] = !hold_mask[i] && ($urandom_range(1, 100) <= valid_pct);
      end else begin
        req_payload[i*DW +: DW] = '0;
        req_last[i]  = 1'b0;
        req_valid[i] = 1'b0;
      end
    end
    push_ready = ($urandom_range(1, 100) <= ready_pct);
    r1_valid   = 1'($urandom_range(0, 1));
    r1_last    = 1'($urandom_range(0, 1));
    r1_payload = $urandom;
    p1_ready   = 1'($urandom_range(0, 1));
  endtask

  // One clock: note accepted requester beats, then present next stimulus
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic drain(input int budget);
    int c = 0;
    valid_pct = 100;
    ready_pct = 100;
    hold_mask = '0;
    while (pending() > 0 && c < budget) begin
      step();
      c++;
    end
    if (pending() > 0) chk("drain_timeout", 1, 0);
    repeat (2) step();
  endtask

  task automatic check_order(input string name, input int exp_ord[$]);
    chk({name, "_len"}, acc_log.size(), exp_ord.size());
    for (int k = 0; k < exp_ord.size() && k < acc_log.size(); k++) chk(name, acc_log[k], exp_ord[k]);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int e;
  logic m_any;
  logic [N-1:0] exp_rdy;
  logic [DW:0] want;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_push_valid", push_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_req_ready", req_ready, 0);
      m_owner = -1;
      m_ptr = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      e = (m_owner >= 0) ? m_owner : rr_pick(req_valid, m_ptr);
      m_any = (m_owner >= 0) || (req_valid != '0);
      exp_rdy = '0;
      exp_rdy[e] = m_any && push_ready;
      chk("grant_id", grant_id, e);
      chk("busy", busy, m_owner >= 0);
      chk("push_valid", push_valid, req_valid[e]);
      chk("req_ready", req_ready, exp_rdy);
      if (req_valid[e]) begin
        chk("push_payload_sel", push_payload, req_payload[e*DW +: DW]);
        chk("push_last_sel", push_last, req_last[e]);
        if (push_ready) begin
          acc_log.push_back(int'(grant_id));
          if (exp_q[e].size() == 0) chk("sb_underflow", 1, 0);
          else begin
            want = exp_q[e].pop_front();
            chk("sb_beat", {push_last, push_payload}, want);
          end
          wait_cnt[e] = 0;
          if (req_last[e]) begin
            for (int i = 0; i < N; i++) begin
              if (i != e && req_valid[i]) begin
                wait_cnt[i]++;
                chk("starvation", wait_cnt[i] > N - 1, 0);
              end
            end
            m_owner = -1;
            m_ptr = (e + 1) % N;
          end else m_owner = e;
        end else m_owner = e;
      end
      for (int i = 0; i < N; i++) if (!req_valid[i]) wait_cnt[i] = 0;
      // single-requester instance is a pass-through
      chk("n1_push_valid", p1_valid, r1_valid);
      chk("n1_grant_id", g1, 0);
      if (r1_valid) begin
        chk("n1_payload", p1_payload, r1_payload);
        chk("n1_last", p1_last, r1_last);
        chk("n1_ready", r1_ready, p1_ready);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [DW-1:0] t_pay;
  initial begin
    req_valid = '0; req_last = '0; req_payload = '0; push_ready = 1'b0;
    r1_valid = '0; r1_last = '0; r1_payload = '0; p1_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    drive();

    // Saturated single-beat traffic: grants rotate one per cycle
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) load_pkt(i, 1);
    drive();
    for (int k = 0; k < 8; k++) begin
      #2 chk("rotate_grant", grant_id, k % 4);
      step();
    end
    repeat (2) step();

    // Stalled beat keeps its grant even when a higher-priority requester appears
    ready_pct = 0;
    t_pay = {8'd1, 24'(seq)};
    load_pkt(1, 1);
    drive();
    for (int k = 0; k < 8; k++) begin
      if (k == 5) begin load_pkt(0, 1); drive(); end
      #2 chk("stall_grant", grant_id, 1);
      chk("stall_payload", push_payload, t_pay);
      step();
    end
    acc_log.delete();
    drain(50);
    check_order("stall_order", '{1, 0});

    // Multi-beat packet from requester 2 is not interrupted by requester 0
    acc_log.delete();
    load_pkt(2, 3);
    load_pkt(0, 1);
    drive();
    drain(50);
    check_order("pkt_order", '{2, 2, 2, 0});

    // Winner drops valid mid-packet: port idles but stays locked
    acc_log.delete();
    load_pkt(1, 4);
    load_pkt(3, 1);
    drive();
    step();
    step();
    hold_mask = 4'b0010;
    drive();
    for (int k = 0; k < 2; k++) begin
      #2 chk("gap_push_valid", push_valid, 0);
      chk("gap_busy", busy, 1);
      chk("gap_grant", grant_id, 1);
      step();
    end
    drain(50);
    check_order("gap_order", '{1, 1, 1, 1, 3});

    // Reset mid-packet while requester 3 holds the grant
    hold_mask = 4'b0001;
    load_pkt(3, 4);
    load_pkt(0, 1);
    drive();
    step();
    step();
    #1 chk("pre_rst_grant", grant_id, 3);
    rst_n = 1'b0;
    #1 chk("mid_rst_push_valid", push_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant_id, 0);
    for (int i = 0; i < N; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    hold_mask = '0;
    load_pkt(3, 2);
    load_pkt(0, 1);
    drive();
    step();
    step();
    #1 rst_n = 1'b1;
    acc_log.delete();
    drain(50);
    check_order("post_rst_order", '{0, 3, 3});

    // Random traffic
    valid_pct = 80;
    ready_pct = 70;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc % 1000 == 999) begin
        valid_pct = $urandom_range(50, 100);
        ready_pct = $urandom_range(30, 100);
      end
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 3 && $urandom_range(0, 3) == 0) load_pkt(i, $urandom_range(1, 4));
      step();
    end
    drain(2000);
    for (int i = 0; i < N; i++) chk("sb_leftover", exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
